// File: rtl/ascon_perm_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : ascon_perm_scheduler_if
// Brief    : Requester-side handshake bundle for the Ascon permutation
//            scheduler: request valid/p12 select, one-hot ready, completion.
// Revision : 1.0 - initial release
// ============================================================================
interface ascon_perm_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0] req_valid_i;
    logic [NUM_REQ-1:0] req_p12_i;
    logic [NUM_REQ-1:0] req_ready_o;
    logic               done_o;
    logic [ID_W-1:0]    done_id_o;

    modport master (
        output req_valid_i,
        output req_p12_i,
        input  req_ready_o,
        input  done_o,
        input  done_id_o
    );

    modport slave (
        input  req_valid_i,
        input  req_p12_i,
        output req_ready_o,
        output done_o,
        output done_id_o
    );
endinterface
`default_nettype wire

// File: rtl/ascon_perm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ascon_perm_scheduler
// Brief    : Round-robin owner of a shared iterative Ascon permutation;
//            sequences load, per-round enables and completion for p12/p6.
// Revision : 1.0 - initial release
// ============================================================================
module ascon_perm_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int RND_WIDTH  = 4,
    parameter int LAST_ROUND = 11,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  wire                  clk_i,
    input  wire                  rst_n_i,
    input  wire                  clear_i,
    ascon_perm_scheduler_if.slave req_if,
    output logic                 rnd_load_o,
    output logic                 rnd_en_o,
    output logic                 rnd_sel_p12_o,
    input  wire [RND_WIDTH-1:0]  round_i,
    output logic [ID_W-1:0]      perm_sel_o,
    output logic                 perm_load_o,
    output logic                 perm_en_o,
    output logic                 busy_o
);

    localparam int unsigned          c_num_req    = NUM_REQ;
    localparam logic [RND_WIDTH-1:0] c_last_round = RND_WIDTH'(LAST_ROUND);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_owner;
    logic            r_p12;

    logic            w_found;
    logic [ID_W-1:0] w_grant_id;
    logic            w_accept;
    logic            w_grant_en;

    // (base + off) mod NUM_REQ without a divider; off never exceeds NUM_REQ-1
    function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] base,
                                               input int unsigned    off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= c_num_req) begin
            sum = sum - c_num_req;
        end
        return sum[ID_W-1:0];
    endfunction

    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        for (int unsigned i = 0; i < c_num_req; i++) begin
            if (!w_found && req_if.req_valid_i[f_wrap(r_ptr, i)]) begin
                w_found    = 1'b1;
                w_grant_id = f_wrap(r_ptr, i);
            end
        end
    end

    assign w_accept   = w_found && (r_state == S_IDLE) && !clear_i;
    // Reset is folded in so no grant leaks out while the block is held in reset
    assign w_grant_en = w_accept && rst_n_i;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
        assign req_if.req_ready_o[g] = w_grant_en && (w_grant_id == ID_W'(g));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_p12   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner <= w_grant_id;
                r_p12   <= req_if.req_p12_i[w_grant_id];
                r_ptr   <= f_wrap(w_grant_id, 1);
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        rnd_load_o       = 1'b0;
        rnd_en_o         = 1'b0;
        rnd_sel_p12_o    = 1'b0;
        perm_load_o      = 1'b0;
        perm_en_o        = 1'b0;
        busy_o           = (r_state != S_IDLE);
        req_if.done_o    = 1'b0;
        req_if.done_id_o = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                rnd_load_o    = 1'b1;
                rnd_en_o      = 1'b1;
                rnd_sel_p12_o = r_p12;
                perm_load_o   = 1'b1;
                w_state_nxt   = S_ROUND;
            end
            S_ROUND: begin
                perm_en_o = 1'b1;
                rnd_en_o  = 1'b1;
                // Equality only: the counter saturates at the last round
                if (round_i == c_last_round) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                req_if.done_o    = !clear_i;
                req_if.done_id_o = clear_i ? '0 : r_owner;
                w_state_nxt      = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (clear_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign perm_sel_o = r_owner;

endmodule
`default_nettype wire
